shift_sub_divider: RTL and testbench

//  Sequential restoring (shift-subtract) divider. It is the inverse datapath of
//  the shift-add multiplier FSM: it divides a 2*WIDTH-bit dividend by a

---
 rtl/shift_sub_divider_pkg.sv | 18 +
 rtl/shift_sub_divider_stage.sv | 32 +++
 rtl/shift_sub_divider.sv | 99 +++++++++
 tb/tb_shift_sub_divider.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/shift_sub_divider_pkg.sv
// Shared definitions for the shift-subtract divider: FSM encoding and counter sizing.
package shift_sub_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 3;

  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(2 * width + 1);
  endfunction

  localparam int unsigned COUNT_W = count_width(DEFAULT_WIDTH);

endpackage

// File: rtl/shift_sub_divider_stage.sv
// One restoring-division step: shift the next dividend bit into the partial remainder
// and subtract the divisor when it fits.
module shift_sub_stage #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH:0]   r_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] divisor_ext;
  logic           unused_r_msb;

  // The incoming remainder is always below the divisor, so its MSB is shifted out as zero.
  assign unused_r_msb = r_in[WIDTH];

  always_comb begin
    shifted     = {r_in[WIDTH-1:0], q_msb};
    divisor_ext = {1'b0, divisor};
    if (shifted >= divisor_ext) begin
      r_out = shifted - divisor_ext;
      q_bit = 1'b1;
    end else begin
      r_out = shifted;
      q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient
// bit per clock, start/busy/done handshake.
module shift_sub_divider
  import shift_sub_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [2*WIDTH-1:0]             dividend,
  input  logic [WIDTH-1:0]               divisor,
  output logic                           busy,
  output logic                           done,
  output logic                           div_by_zero,
  output logic [2*WIDTH-1:0]             quotient,
  output logic [WIDTH-1:0]               remainder,
  output logic [$clog2(2*WIDTH+1)-1:0]   count_out
);

  localparam int unsigned CNT_W = count_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(2 * WIDTH - 1);

  state_t               state_q;
  logic [2*WIDTH-1:0]   q_q;
  logic [WIDTH:0]       r_q;
  logic [WIDTH-1:0]     divisor_q;
  logic [WIDTH:0]       stage_r;
  logic                 stage_q_bit;

  shift_sub_stage #(
    .WIDTH (WIDTH)
  ) u_stage (
    .r_in    (r_q),
    .q_msb   (q_q[2*WIDTH-1]),
    .divisor (divisor_q),
    .r_out   (stage_r),
    .q_bit   (stage_q_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      q_q         <= '0;
      r_q         <= '0;
      divisor_q   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      count_out   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // The done cycle still belongs to the finished operation.
          if (start && !done) begin
            q_q         <= dividend;
            divisor_q   <= divisor;
            r_q         <= '0;
            count_out   <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_RUN;
              busy    <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_q       <= stage_r;
          q_q       <= {q_q[2*WIDTH-2:0], stage_q_bit};
          count_out <= count_out + CNT_ONE;
          if (count_out == LAST_ITER) begin
            state_q <= ST_DONE;
            busy    <= 1'b0;
          end
        end
        ST_DONE: begin
          done    <= 1'b1;
          state_q <= ST_IDLE;
          if (divisor_q == '0) begin
            div_by_zero <= 1'b1;
            quotient    <= '1;
            remainder   <= q_q[WIDTH-1:0];
          end else begin
            quotient  <= q_q;
            remainder <= r_q[WIDTH-1:0];
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider (WIDTH=3): vector table plus scoreboard queue,
// with hand-written sequences for ignored starts and reset mid-operation.
module tb_shift_sub_divider;

  localparam int unsigned W = 3;

  typedef struct {
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           dbz;
    logic [2:0]     cnt;
    int             lat;
  } vec_t;

  logic           clk;
  logic           reset;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [2*W-1:0] quotient;
  logic [W-1:0]   remainder;
  logic [2:0]     count_out;

  int   total = 0;
  int   bad   = 0;
  vec_t sb[$];
  vec_t table_v[8];

  shift_sub_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder),
    .count_out   (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int q, input int r, input int z,
                              input int lat);
    vec_t v;
    v.dvd = (2*W)'(a);
    v.dvs = W'(b);
    v.q   = (2*W)'(q);
    v.r   = W'(r);
    v.dbz = z[0];
    v.cnt = (z != 0) ? 3'd0 : 3'd6;
    v.lat = lat;
    return v;
  endfunction

  // Runs one division; poke re-asserts start with 10/3 during RUN and DONE.
  task automatic do_op(input vec_t e, input bit poke);
    int   edges;
    vec_t got;
    @(negedge clk);
    dividend = e.dvd;
    divisor  = e.dvs;
    start    = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~e.dvd;
    divisor  = e.dvs ^ 3'b101;
    check("busy_after_start", 32'(busy), e.dbz ? 32'd0 : 32'd1);
    edges = 0;
    while (edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
      if (poke && edges == 2) begin
        start    = 1'b1;
        dividend = 6'd10;
        divisor  = 3'd3;
      end
    end
    start = 1'b0;
    check("latency", 32'(edges), 32'(e.lat));
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("quotient", 32'(quotient), 32'(got.q));
      check("remainder", 32'(remainder), 32'(got.r));
      check("div_by_zero", 32'(div_by_zero), 32'(got.dbz));
      check("count_out", 32'(count_out), 32'(got.cnt));
      check("busy_at_done", 32'(busy), 32'd0);
    end else begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
    end
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    table_v[0] = mk(42, 5, 8, 2, 0, 7);
    table_v[1] = mk(63, 1, 63, 0, 0, 7);
    table_v[2] = mk(63, 7, 9, 0, 0, 7);
    table_v[3] = mk(5, 7, 0, 5, 0, 7);
    table_v[4] = mk(20, 0, 63, 4, 1, 1);
    table_v[5] = mk(0, 3, 0, 0, 0, 7);
    table_v[6] = mk(7, 7, 1, 0, 0, 7);
    table_v[7] = mk(50, 6, 8, 2, 0, 7);
    for (int i = 0; i < 8; i++) begin
      do_op(table_v[i], 1'b0);
    end

    // A zero divisor result must not leak into the next operation's flag.
    do_op(mk(9, 2, 4, 1, 0, 7), 1'b0);

    for (int i = 0; i < 6; i++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 63));
      b = int'($urandom_range(1, 7));
      do_op(mk(a, b, a / b, a % b, 0, 7), 1'b0);
    end

    // Start during RUN/DONE is ignored; a later start in IDLE is honoured.
    do_op(mk(42, 5, 8, 2, 0, 7), 1'b1);
    do_op(mk(10, 3, 3, 1, 0, 7), 1'b0);

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    dividend = 6'd42;
    divisor  = 3'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("count_mid_run", 32'(count_out), 32'd3);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_count", 32'(count_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle_done", 32'(done), 32'd0);
    do_op(mk(42, 5, 8, 2, 0, 7), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
